hand_scorer: RTL

- Producer side of the hand/outcome interface consumed by the seven-segment display block.
- Accepts dealt cards one at a time through a valid/ready handshake and keeps running player and dealer totals, including soft-ace handling.
- On request, compares the hands and drives the 2-bit win-state code (LOSE/TIE/WIN/BJ) shown at end of game.

---
 rtl/hand_scorer.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/hand_scorer.sv
// Blackjack hand scorer: accepts dealt cards over a valid/ready handshake, tracks
// player/dealer totals with soft-ace handling and produces the end-of-game win code.
module hand_scorer #(
    parameter int BUST_LIMIT = 21,
    parameter int DISP_MAX   = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear_hands,
    input  logic       card_valid,
    output logic       card_ready,
    input  logic [3:0] card_value,
    input  logic       card_to_dealer,
    input  logic       evaluate,
    output logic [4:0] playerHand,
    output logic [4:0] dealerHand,
    output logic       player_bust,
    output logic       dealer_bust,
    output logic [1:0] displayState,
    output logic       result_valid
);

    localparam logic [5:0] BUST6 = 6'(BUST_LIMIT);
    localparam logic [5:0] DISP6 = 6'(DISP_MAX);
    localparam logic [1:0] LOSE  = 2'b00;
    localparam logic [1:0] TIE   = 2'b01;
    localparam logic [1:0] WIN   = 2'b10;
    localparam logic [1:0] BJ    = 2'b11;

    typedef enum logic [2:0] {IDLE, ADD, ADJUST, EVAL, DONE} scorerState_e;

    scorerState_e state, nextState;

    logic [5:0] pTotal, dTotal;
    logic [2:0] pSoft, dSoft;
    logic [2:0] pCount, dCount;
    logic       pendEval;
    logic [3:0] cardVal;
    logic       cardDealer;

    logic [5:0] selTotal, addTotal;
    logic [2:0] selSoft, selCount, addSoft, addCount;
    logic       selBust, needAdjust;

    function automatic logic cardIsValid(input logic [3:0] v);
        return (v >= 4'd1) && (v <= 4'd13);
    endfunction

    function automatic logic [5:0] cardPoints(input logic [3:0] v);
        if (v == 4'd1)
            return 6'd11;
        else if (v >= 4'd2 && v <= 4'd10)
            return {2'b00, v};
        else if (v >= 4'd11 && v <= 4'd13)
            return 6'd10;
        else
            return 6'd0;
    endfunction

    function automatic logic [4:0] satHand(input logic [5:0] t);
        return (t > DISP6) ? DISP6[4:0] : t[4:0];
    endfunction

    function automatic logic [1:0] outcome(input logic [5:0] pt, input logic [5:0] dt,
                                           input logic [2:0] pc, input logic [2:0] dc);
        logic pBj, dBj;
        pBj = (pc == 3'd2) && (pt == BUST6);
        dBj = (dc == 3'd2) && (dt == BUST6);
        if (pt > BUST6)       return LOSE;
        else if (pBj && dBj)  return TIE;
        else if (pBj)         return BJ;
        else if (dt > BUST6)  return WIN;
        else if (pt > dt)     return WIN;
        else if (pt == dt)    return TIE;
        else                  return LOSE;
    endfunction

    // The latched card always targets one hand; ADD and ADJUST work on that selection.
    assign selTotal   = cardDealer ? dTotal : pTotal;
    assign selSoft    = cardDealer ? dSoft  : pSoft;
    assign selCount   = cardDealer ? dCount : pCount;
    assign selBust    = selTotal > BUST6;
    assign addTotal   = selTotal + cardPoints(cardVal);
    assign addSoft    = selSoft + {2'b00, (cardVal == 4'd1)};
    assign addCount   = (selCount == 3'd7) ? 3'd7 : selCount + 3'd1;
    assign needAdjust = selBust && (selSoft != 3'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= nextState;
    end

    always_comb begin
        nextState  = state;
        card_ready = (state == IDLE);
        if (clear_hands) begin
            nextState = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (card_valid)
                        nextState = ADD;
                    else if (evaluate || pendEval)
                        nextState = EVAL;
                end
                ADD:     nextState = ADJUST;
                ADJUST:  nextState = IDLE;
                EVAL:    nextState = DONE;
                DONE:    nextState = DONE;
                default: nextState = IDLE;
            endcase
        end
    end

    // Card payload register; only meaningful between a transfer and the end of ADJUST.
    always_ff @(posedge clk) begin
        if (state == IDLE && card_valid) begin
            cardVal    <= card_value;
            cardDealer <= card_to_dealer;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pTotal       <= '0;
            dTotal       <= '0;
            pSoft        <= '0;
            dSoft        <= '0;
            pCount       <= '0;
            dCount       <= '0;
            pendEval     <= 1'b0;
            playerHand   <= '0;
            dealerHand   <= '0;
            player_bust  <= 1'b0;
            dealer_bust  <= 1'b0;
            displayState <= LOSE;
            result_valid <= 1'b0;
        end else if (clear_hands) begin
            pTotal       <= '0;
            dTotal       <= '0;
            pSoft        <= '0;
            dSoft        <= '0;
            pCount       <= '0;
            dCount       <= '0;
            pendEval     <= 1'b0;
            playerHand   <= '0;
            dealerHand   <= '0;
            player_bust  <= 1'b0;
            dealer_bust  <= 1'b0;
            displayState <= LOSE;
            result_valid <= 1'b0;
        end else begin
            // Outputs skip the post-ADD sample so an unadjusted soft total never shows.
            if (state != ADJUST) begin
                playerHand  <= satHand(pTotal);
                dealerHand  <= satHand(dTotal);
                player_bust <= pTotal > BUST6;
                dealer_bust <= dTotal > BUST6;
            end
            unique case (state)
                IDLE: begin
                    if (card_valid)
                        pendEval <= pendEval | evaluate;
                    else if (evaluate || pendEval)
                        pendEval <= 1'b0;
                end
                ADD: begin
                    if (evaluate)
                        pendEval <= 1'b1;
                    if (!selBust && cardIsValid(cardVal)) begin
                        if (cardDealer) begin
                            dTotal <= addTotal;
                            dSoft  <= addSoft;
                            dCount <= addCount;
                        end else begin
                            pTotal <= addTotal;
                            pSoft  <= addSoft;
                            pCount <= addCount;
                        end
                    end
                end
                ADJUST: begin
                    if (evaluate)
                        pendEval <= 1'b1;
                    if (needAdjust) begin
                        if (cardDealer) begin
                            dTotal <= selTotal - 6'd10;
                            dSoft  <= selSoft - 3'd1;
                        end else begin
                            pTotal <= selTotal - 6'd10;
                            pSoft  <= selSoft - 3'd1;
                        end
                    end
                end
                EVAL: begin
                    displayState <= outcome(pTotal, dTotal, pCount, dCount);
                    result_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
